// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regfile_writeback_pkg;

  // Datapath word width of the register file.
  localparam int WORD = 32;

  // Nominal clock period used by simulation models.
  localparam int CYCLE = 10;

  // Architectural register 0 is hardwired to zero.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // One pending write-back: destination register and its result value.
  typedef struct packed {
    logic [4:0]      dest;
    logic [WORD-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue.sv
// In-order circular buffer of pending write-backs.
// Exposes every slot together with its valid flag and age (distance from the head),
// so the parent can run a youngest-match search for forwarding.
module writeback_queue
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_entry,
  input  logic                       i_pop,
  output logic [PW:0]                o_count,
  output wb_entry_t                  o_head,
  output wb_entry_t [DEPTH-1:0]      o_entries,
  output logic [DEPTH-1:0]           o_valid,
  output logic [DEPTH-1:0][PW-1:0]   o_age
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW:0]           r_count;

  // Storage, pointers and occupancy; push and pop may happen on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Age of each slot relative to the head; a slot is live when its age is below count.
  always_comb begin
    o_age   = '0;
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_age[i]   = PW'(i) - r_rd_ptr;
      o_valid[i] = ({1'b0, o_age[i]} < r_count);
    end
  end

  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_entries = r_mem;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back controller owning the register file's single write port.
// Accepts results over valid/ready, drops writes to register 0, retires the queue
// head whenever the port is free, and forwards the youngest pending value per query.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_dest,
  input  logic [WORD-1:0] in_data,
  input  logic            stall,
  output logic            write,
  output logic [4:0]      address_dest,
  output logic [WORD-1:0] write_data,
  input  logic [4:0]      query_A,
  input  logic [4:0]      query_B,
  output logic            fwd_hit_A,
  output logic            fwd_hit_B,
  output logic [WORD-1:0] fwd_data_A,
  output logic [WORD-1:0] fwd_data_B
);

  logic [PW:0]              w_count;
  wb_entry_t                w_head;
  wb_entry_t [DEPTH-1:0]    w_entries;
  logic [DEPTH-1:0]         w_valid;
  logic [DEPTH-1:0][PW-1:0] w_age;
  logic                     w_push;
  logic                     w_pop;
  wb_entry_t                w_push_entry;

  // Youngest live entry whose destination matches the query; register 0 never hits.
  function automatic logic [WORD:0] fwd_search(
    input logic [4:0]               query,
    input wb_entry_t [DEPTH-1:0]    entries,
    input logic [DEPTH-1:0]         valid,
    input logic [DEPTH-1:0][PW-1:0] age
  );
    logic            hit;
    logic [PW-1:0]   best_age;
    logic [WORD-1:0] data;
    hit      = 1'b0;
    best_age = '0;
    data     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].dest == query) && (query != REG_ZERO) &&
          (!hit || (age[i] > best_age))) begin
        hit      = 1'b1;
        best_age = age[i];
        data     = entries[i].data;
      end
    end
    return {hit, data};
  endfunction

  assign in_ready           = !reset && (w_count < (PW+1)'(DEPTH));
  assign w_push             = in_valid && in_ready && (in_dest != REG_ZERO);
  assign w_push_entry.dest  = in_dest;
  assign w_push_entry.data  = in_data;
  assign w_pop              = write;

  writeback_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head       (w_head),
    .o_entries    (w_entries),
    .o_valid      (w_valid),
    .o_age        (w_age)
  );

  // Head entry drives the regfile port whenever it exists and the port is free.
  always_comb begin
    write        = 1'b0;
    address_dest = 5'd0;
    write_data   = '0;
    if ((w_count != '0) && !stall) begin
      write        = 1'b1;
      address_dest = w_head.dest;
      write_data   = w_head.data;
    end else begin
      write        = 1'b0;
      address_dest = 5'd0;
      write_data   = '0;
    end
  end

  // Two independent forwarding lookups over the queued entries.
  always_comb begin
    {fwd_hit_A, fwd_data_A} = fwd_search(query_A, w_entries, w_valid, w_age);
    {fwd_hit_B, fwd_data_B} = fwd_search(query_B, w_entries, w_valid, w_age);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised and directed bench for regfile_writeback against a queue-based reference.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_dest;
  logic [WORD-1:0] in_data;
  logic            stall;
  logic            write;
  logic [4:0]      address_dest;
  logic [WORD-1:0] write_data;
  logic [4:0]      query_A, query_B;
  logic            fwd_hit_A, fwd_hit_B;
  logic [WORD-1:0] fwd_data_A, fwd_data_B;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .stall(stall), .write(write), .address_dest(address_dest), .write_data(write_data),
    .query_A(query_A), .query_B(query_B),
    .fwd_hit_A(fwd_hit_A), .fwd_hit_B(fwd_hit_B),
    .fwd_data_A(fwd_data_A), .fwd_data_B(fwd_data_B)
  );

  always #(CYCLE/2) clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pending results in acceptance order, and the architectural regfile.
  wb_entry_t       model_q[$];
  logic [WORD-1:0] model_rf[32];
  logic [WORD-1:0] dut_rf[32];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected forwarding result: scan from youngest to oldest pending entry.
  function automatic logic [WORD:0] model_fwd(input logic [4:0] q);
    for (int k = model_q.size() - 1; k >= 0; k--) begin
      if (q != 5'd0 && model_q[k].dest == q) return {1'b1, model_q[k].data};
    end
    return {1'b0, {WORD{1'b0}}};
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance model at posedge.
  task automatic cycle(input logic v, input logic [4:0] d, input logic [WORD-1:0] dat,
                       input logic st, input logic [4:0] qa, input logic [4:0] qb);
    logic exp_ready, exp_write, obs_write, obs_ready;
    logic [4:0] obs_addr;
    logic [WORD-1:0] obs_data;
    logic [WORD:0] fa, fb;
    wb_entry_t e;
    @(negedge clk);
    in_valid = v; in_dest = d; in_data = dat; stall = st; query_A = qa; query_B = qb;
    #1;
    exp_ready = (model_q.size() < DEPTH);
    exp_write = (model_q.size() != 0) && !st;
    fa = model_fwd(qa);
    fb = model_fwd(qb);
    check_val("in_ready", 64'(in_ready), 64'(exp_ready));
    check_val("write", 64'(write), 64'(exp_write));
    check_val("address_dest", 64'(address_dest), exp_write ? 64'(model_q[0].dest) : 64'd0);
    check_val("write_data", 64'(write_data), exp_write ? 64'(model_q[0].data) : 64'd0);
    check_val("fwd_A", {31'd0, fwd_hit_A, fwd_data_A}, 64'(fa));
    check_val("fwd_B", {31'd0, fwd_hit_B, fwd_data_B}, 64'(fb));
    obs_write = write; obs_addr = address_dest; obs_data = write_data; obs_ready = in_ready;
    @(posedge clk);
    if (obs_write) dut_rf[obs_addr] = obs_data;
    if (exp_write) begin
      model_rf[model_q[0].dest] = model_q[0].data;
      void'(model_q.pop_front());
    end
    if (v && exp_ready && d != 5'd0) begin
      e.dest = d; e.data = dat;
      model_q.push_back(e);
    end
  endtask

  // Occupancy observed inside the design after the last edge.
  task automatic check_count(input string tag);
    #1;
    check_val(tag, 64'(dut.u_queue.o_count), 64'(model_q.size()));
  endtask

  logic            h_valid;
  logic [4:0]      h_dest;
  logic [WORD-1:0] h_data;
  logic            h_pending;

  initial begin
    for (int r = 0; r < 32; r++) begin
      model_rf[r] = '0;
      dut_rf[r]   = '0;
    end
    reset = 1'b1; in_valid = 1'b0; in_dest = 5'd0; in_data = '0; stall = 1'b0;
    query_A = 5'd0; query_B = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_in_ready", 64'(in_ready), 64'd0);
    check_val("reset_write", 64'(write), 64'd0);
    check_val("reset_fwd_hit", 64'({fwd_hit_A, fwd_hit_B}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Latency into an empty queue.
    cycle(1'b1, 5'd2, 32'd10, 1'b0, 5'd2, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd2, 5'd2);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    check_val("rf2_after_latency", 64'(dut_rf[2]), 64'd10);

    // Duplicate destination under stall, youngest forwarded.
    cycle(1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 5'd2);
    cycle(1'b1, 5'd5, 32'd9, 1'b1, 5'd5, 5'd5);
    check_count("count_two");
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
    check_val("fwd_dup_youngest", 64'(fwd_data_A), 64'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    check_val("rf5_last_wins", 64'(dut_rf[5]), 64'd9);

    // Fill under stall; fifth waits, one retire frees a slot.
    for (int k = 0; k < 5; k++) cycle(1'b1, 5'(k + 10), 32'(100 + k), 1'b1, 5'd12, 5'd14);
    check_val("full_not_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 5'd14, 32'd104, 1'b0, 5'd14, 5'd10);
    cycle(1'b1, 5'd14, 32'd104, 1'b1, 5'd14, 5'd11);
    check_count("count_refill");
    repeat (5) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd14, 5'd13);
    check_val("rf14_drained", 64'(dut_rf[14]), 64'd104);

    // Register zero is discarded.
    cycle(1'b1, 5'd0, 32'd16, 1'b0, 5'd0, 5'd0);
    check_count("count_zero_drop");
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    // Simultaneous accept and retire with one entry queued.
    cycle(1'b1, 5'd7, 32'd70, 1'b1, 5'd7, 5'd8);
    cycle(1'b1, 5'd8, 32'd80, 1'b0, 5'd7, 5'd8);
    check_count("count_push_pop");
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd8);

    // Asynchronous reset with three entries pending.
    for (int k = 0; k < 3; k++) cycle(1'b1, 5'(k + 20), 32'(200 + k), 1'b1, 5'd21, 5'd22);
    @(negedge clk);
    in_valid = 1'b0; query_A = 5'd21; query_B = 5'd22; stall = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst_write", 64'(write), 64'd0);
    check_val("async_rst_ready", 64'(in_ready), 64'd0);
    check_val("async_rst_fwd", 64'({fwd_hit_A, fwd_hit_B}), 64'd0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd21, 5'd20);
    check_val("rf20_untouched", 64'(dut_rf[20]), 64'd0);

    // Random traffic; producer holds its offer while not accepted.
    h_pending = 1'b0; h_valid = 1'b0; h_dest = 5'd0; h_data = '0;
    for (int n = 0; n < 400; n++) begin
      if (!h_pending) begin
        h_valid = ($urandom_range(0, 9) < 7);
        h_dest  = 5'($urandom_range(0, 7));
        h_data  = $urandom;
      end
      h_pending = h_valid && (model_q.size() >= DEPTH);
      cycle(h_valid, h_dest, h_data, ($urandom_range(0, 9) < 3),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    while (model_q.size() != 0 && n_checks < 100000) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    for (int r = 0; r < 32; r++) check_val($sformatf("rf_%0d", r), 64'(dut_rf[r]), 64'(model_rf[r]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
